recop_fetch_unit: RTL and testbench

//  Instruction fetch stage directly downstream of the ReCOP program memory.
//  - Drives the 2048x16 single-port program RAM: 1-cycle read latency; address registered on clk when clken=1.
//  - Reads each two-word ReCOP instruction: word0 = AM/opcode/Rz/Rx, word1 = operand.
//  - Assembles it into one 32-bit instruction with its PC.
//  - Presents the instruction to decode over a valid/ready handshake; supports branch redirect/flush.

---
 rtl/recop_fetch_unit.sv | 109 ++++++++++
 tb/tb_recop_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/recop_fetch_unit.sv
// ReCOP instruction fetch: reads two 16-bit program words per instruction and
// hands {word0, word1} with its PC to decode over a valid/ready handshake.
module recop_fetch_unit #(
  parameter int unsigned           ADDR_W   = 11,
  parameter int unsigned           DATA_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  output logic [ADDR_W-1:0]     pm_address,
  output logic                  pm_clken,
  input  logic [DATA_W-1:0]     pm_readdata,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [2*DATA_W-1:0]   instr_word,
  output logic [ADDR_W-1:0]     instr_pc
);

  typedef enum logic [1:0] {IDLE, W0, W1} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   fp, fp_n, ipc, ipc_n, pc_n;
  logic [DATA_W-1:0]   hi, hi_n;
  logic [2*DATA_W-1:0] word_n;
  logic                valid_n, issue, accept;

  assign accept     = instr_valid & instr_ready;
  assign pm_address = redirect ? redirect_pc : fp;
  // Gated by reset so the RAM is never enabled while reset is held, even if redirect is asserted.
  assign pm_clken   = issue & reset_n;

  always_comb begin
    state_n = state;
    fp_n    = fp;
    ipc_n   = ipc;
    hi_n    = hi;
    valid_n = instr_valid;
    word_n  = instr_word;
    pc_n    = instr_pc;
    issue   = 1'b0;

    if (accept) valid_n = 1'b0;

    if (redirect) begin
      issue   = 1'b1;
      valid_n = 1'b0;
      hi_n    = '0;
      ipc_n   = redirect_pc;
      state_n = W0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en) begin
            issue   = 1'b1;
            ipc_n   = fp;
            state_n = W0;
          end
        end
        W0: begin
          hi_n    = pm_readdata;
          issue   = 1'b1;
          state_n = W1;
        end
        W1: begin
          // With the slot occupied the RAM stays disabled so its output keeps word1.
          if (!instr_valid || accept) begin
            valid_n = 1'b1;
            word_n  = {hi, pm_readdata};
            pc_n    = ipc;
            if (fetch_en) begin
              issue   = 1'b1;
              ipc_n   = fp;
              state_n = W0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (issue) fp_n = pm_address + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fp          <= RESET_PC;
      ipc         <= RESET_PC;
      hi          <= '0;
      instr_valid <= 1'b0;
      instr_word  <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_n;
      fp          <= fp_n;
      ipc         <= ipc_n;
      hi          <= hi_n;
      instr_valid <= valid_n;
      instr_word  <= word_n;
      instr_pc    <= pc_n;
    end
  end

endmodule

// File: tb/tb_recop_fetch_unit.sv
// Directed bench for recop_fetch_unit with a behavioural 2048x16 registered-read program RAM.
module tb_recop_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [10:0] pm_address;
  logic        pm_clken;
  logic [15:0] pm_readdata;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [10:0] instr_pc;

  logic [15:0] mem [0:2047];
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (pm_clken) pm_readdata <= mem[pm_address];

  recop_fetch_unit #(.ADDR_W(11), .DATA_W(16), .RESET_PC(11'h000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_en    (fetch_en),
    .pm_address  (pm_address),
    .pm_clken    (pm_clken),
    .pm_readdata (pm_readdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .instr_pc    (instr_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_instr(input string tag, input logic [31:0] w, input logic [10:0] pc);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_word"}, instr_word, w);
    check({tag, "_pc"}, {21'd0, instr_pc}, {21'd0, pc});
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'hC000 | 16'(i);
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
    reset_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    step(); step();
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_word", instr_word, 32'd0);
    check("rst_pc", {21'd0, instr_pc}, 32'd0);
    check("rst_clken", {31'd0, pm_clken}, 32'd0);

    // 1: basic fetch, valid on the 3rd edge
    reset_n = 1'b1; fetch_en = 1'b1;
    step();                                   // edge 1: issue 0
    step();                                   // edge 2: issue 1
    check("t1_early_valid", {31'd0, instr_valid}, 32'd0);
    step();                                   // edge 3
    check_instr("t1_i0", 32'h12345678, 11'h000);
    step();
    check("t1_accept_clr", {31'd0, instr_valid}, 32'd0);
    step();
    check_instr("t1_i1", 32'h9ABCDEF0, 11'h002);

    // 2: backpressure holds the output and the RAM
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_instr("t2_hold", 32'h9ABCDEF0, 11'h002);
      if (c > 0) begin
        check("t2_clken", {31'd0, pm_clken}, 32'd0);
        check("t2_addr", {21'd0, pm_address}, 32'h006);
      end
    end
    instr_ready = 1'b1;
    step();
    check_instr("t2_next", 32'hC004C005, 11'h004);
    step();
    check("t2_gap", {31'd0, instr_valid}, 32'd0);
    step();
    check_instr("t2_seq", 32'hC006C007, 11'h006);

    // 3: redirect while stalled
    instr_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 11'h100;
    #1;
    check("t3_addr", {21'd0, pm_address}, 32'h100);
    check("t3_clken", {31'd0, pm_clken}, 32'd1);
    step();
    redirect = 1'b0; instr_ready = 1'b1;
    check("t3_flush", {31'd0, instr_valid}, 32'd0);
    step();
    check("t3_w0", {31'd0, instr_valid}, 32'd0);
    step();
    check_instr("t3_tgt", 32'hC100C101, 11'h100);

    // 4: wrap-around at the top of program memory
    mem[11'h7FF] = 16'hAAAA; mem[0] = 16'h5555;
    redirect = 1'b1; redirect_pc = 11'h7FF;
    step();
    redirect = 1'b0;
    check("t4_flush", {31'd0, instr_valid}, 32'd0);
    step();
    step();
    check_instr("t4_wrap", 32'hAAAA5555, 11'h7FF);
    step();
    step();
    check_instr("t4_after", 32'h56789ABC, 11'h001);

    // 5: asynchronous reset while in W1 with a held instruction
    instr_ready = 1'b0;
    step();
    check("t5_pre_valid", {31'd0, instr_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_clken", {31'd0, pm_clken}, 32'd0);
    check("t5_word", instr_word, 32'd0);
    instr_ready = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step(); step();
    check("t5_wait", {31'd0, instr_valid}, 32'd0);
    step();
    check_instr("t5_first", 32'h55555678, 11'h000);

    // 6: fetch_en drops in W0; in-flight instruction completes then idles
    fetch_en = 1'b0;
    step();
    step();
    check_instr("t6_last", 32'h9ABCDEF0, 11'h002);
    check("t6_clken_off", {31'd0, pm_clken}, 32'd0);
    step();
    check("t6_idle_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_idle_clken", {31'd0, pm_clken}, 32'd0);
    check("t6_idle_addr", {21'd0, pm_address}, 32'h004);
    step();
    fetch_en = 1'b1;
    #1;
    check("t6_resume_clken", {31'd0, pm_clken}, 32'd1);
    step(); step(); step();
    check_instr("t6_resume", 32'hC004C005, 11'h004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
